strip_scan_ctrl: RTL
====================

# strip_scan_ctrl

Scan controller that time-shares one strip frame checker across NCH strip links. It selects one link at a time, waits for that link to lock, and assembles 4-word frames from the selected stream. After a programmable number of good frames it reports frame and error counts for that channel, then advances round-robin to the next channel. It sits between the per-link strip deserializers/link monitors and the shared frame checker and debug logic, all on clk160.

## Interface
- NCH, 8, number of strip links (≥2); CHW = $clog2(NCH)
- SETTLE_CYC, 4, cycles of dead time after a channel switch (≥2)
- LINK_TIMEOUT, 1024, cycles to wait for link lock before declaring link failure
- clk160  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run scanning; low returns to IDLE
- dwell_frames  in  16  good frames to collect per channel; 0 is treated as 1
- strip_data_in  in  NCH*30  link k occupies bits [30k+29:30k]; [29:26] header, [25:0] payload
- link_locked  in  NCH  per-link lock from the link monitors
- sel_ch  out  CHW  currently selected channel
- mux_data  out  30  registered copy of the selected link word
- frame_data  out  104  {w0,w1,w2,w3} payloads, w0 in [103:78]
- frame_valid  out  1  one-cycle strobe for a good frame
- result_valid  out  1  one-cycle strobe at the end of a channel dwell
- result_ch  out  CHW  channel being reported
- result_frames  out  16  good frames counted
- result_errors  out  16  length errors counted, saturating at 16'hFFFF
- result_link_fail  out  1  dwell ended by lock timeout or lock loss
- state  out  3  IDLE=0, SETTLE=1, WAIT_LINK=2, DWELL=3, REPORT=4

## Operation
- Reset: all outputs 0, sel_ch=0, state=IDLE, and all counters and assembler state cleared.
- IDLE: leaves for SETTLE when enable=1, keeping sel_ch unchanged.
- SETTLE: held for SETTLE_CYC cycles, then goes to WAIT_LINK. The assembler is un-primed.
- WAIT_LINK: goes to DWELL when link_locked[sel_ch]=1. After LINK_TIMEOUT cycles without lock it goes to REPORT with result_link_fail=1 and both counts 0.
- DWELL: the assembler is active.
  - Exits to REPORT when the good-frame count reaches max(dwell_frames,1).
  - Exits to REPORT with link_fail=1 if link_locked[sel_ch] drops. Counts are kept.
- REPORT: result_valid=1 for one cycle with the result_* fields. Next cycle sel_ch advances (NCH-1 wraps to 0) and the state goes to SETTLE.
- enable=0 in any state: the next state is IDLE, counters clear, no result is issued, and sel_ch is held.
- Assembler, operating on mux_data:
  - A header word has [29:26]=4'b1010.
  - The assembler primes on the first non-header word seen in DWELL. Runs already in progress at DWELL entry are ignored.
  - Once primed, each header word appends its payload and increments the run length, which saturates at 7.
  - A non-header word ends the run:
    - run length 4: good frame; frame_valid pulses and the good count increments.
    - run length 1–3 or ≥5: result_errors increments, saturating.
    - run length 0: no action.
  - A run still open at DWELL exit is discarded.

## Timing
- mux_data equals strip_data_in of sel_ch, delayed 1 cycle.
- After a sel_ch change, mux_data carries the new channel 1 cycle later. SETTLE_CYC≥2 guarantees no stale word reaches the primed assembler.
- frame_valid and frame_data are registered. They are asserted the cycle after mux_data shows the terminating non-header word, i.e. 2 cycles after that word on strip_data_in.
- frame_data holds its value between strobes.
- The good-frame count that hits the target moves the state to REPORT on the following cycle. result_valid is asserted exactly 1 cycle in REPORT.
- result_* fields hold until the next REPORT.
- A lock loss and the final good frame arriving in the same cycle count the frame and set link_fail=1.
- Asynchronous reset mid-dwell aborts the dwell with no result.

## Test plan
- NCH=4, dwell_frames=3, all links locked, each link sends the 4-word frame header 1010 with payloads 26'h1,2,3,4 followed by 1 idle word, repeated. Required response:
  - 3 frame_valid strobes per channel, each with frame_data={26'h1,26'h2,26'h3,26'h4}.
  - result_frames=3, result_errors=0, result_ch cycling 0,1,2,3,0.
- Link 2 sends runs of length 3 and 5 interleaved with good frames, dwell_frames=2 → result_ch=2, result_frames=2, result_errors=2.
- link_locked[1]=0 permanently, LINK_TIMEOUT=16 → channel 1 reports link_fail=1 with frames=0, 16 cycles after WAIT_LINK entry. The scan then continues to channel 2.
- link_locked[0] drops after 1 good frame, dwell_frames=5 → result_frames=1, link_fail=1.
- enable deasserted mid-DWELL on channel 3 → state=IDLE next cycle with no result_valid. Re-enable restarts channel 3 from SETTLE with counts 0.
- dwell_frames=0 → treated as 1: one frame per channel is reported. A frame already in flight at DWELL entry is not counted.

Source files
------------

// File: rtl/strip_scan_ctrl.sv
// strip_scan_ctrl: round-robin scan of NCH strip links through one shared
// frame checker. Each visit settles the mux, waits for lock, collects a
// programmable number of good 4-word frames and reports per-channel counts.
module strip_scan_ctrl #(
  parameter int NCH          = 8,
  parameter int SETTLE_CYC   = 4,
  parameter int LINK_TIMEOUT = 1024,
  localparam int CHW         = $clog2(NCH)
) (
  input  logic               clk160,
  input  logic               reset,
  input  logic               enable,
  input  logic [15:0]        dwell_frames,
  input  logic [NCH*30-1:0]  strip_data_in,
  input  logic [NCH-1:0]     link_locked,
  output logic [CHW-1:0]     sel_ch,
  output logic [29:0]        mux_data,
  output logic [103:0]       frame_data,
  output logic               frame_valid,
  output logic               result_valid,
  output logic [CHW-1:0]     result_ch,
  output logic [15:0]        result_frames,
  output logic [15:0]        result_errors,
  output logic               result_link_fail,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_WAIT_LINK = 3'd2,
    S_DWELL     = 3'd3,
    S_REPORT    = 3'd4
  } state_t;

  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int TCW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [SCW-1:0] SETTLE_LAST  = SCW'(SETTLE_CYC - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(LINK_TIMEOUT - 1);
  localparam logic [CHW-1:0] CH_LAST      = CHW'(NCH - 1);
  localparam logic [3:0]     HDR          = 4'b1010;

  state_t           state_q, state_d;
  logic [CHW-1:0]   sel_ch_q, sel_ch_d;
  logic [29:0]      mux_data_q, mux_data_d;
  logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [TCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             primed_q, primed_d;
  logic [2:0]       run_len_q, run_len_d;
  logic [103:0]     acc_q, acc_d;
  logic [15:0]      good_cnt_q, good_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             frame_valid_q, frame_valid_d;
  logic [103:0]     frame_data_q, frame_data_d;
  logic             result_valid_q, result_valid_d;
  logic [CHW-1:0]   result_ch_q, result_ch_d;
  logic [15:0]      result_frames_q, result_frames_d;
  logic [15:0]      result_errors_q, result_errors_d;
  logic             result_link_fail_q, result_link_fail_d;

  logic [29:0]      link_word [NCH];
  logic             sel_locked;
  logic [15:0]      dwell_target;
  logic             target_hit;
  logic             is_hdr;
  logic             asm_active;

  // Split the flat link bus into one word per channel for the mux.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_link
      assign link_word[gi] = strip_data_in[30*gi +: 30];
    end
  endgenerate

  assign sel_locked   = link_locked[sel_ch_q];
  assign dwell_target = (dwell_frames == 16'd0) ? 16'd1 : dwell_frames;
  assign target_hit   = (good_cnt_q >= dwell_target);
  assign is_hdr       = (mux_data_q[29:26] == HDR);
  assign asm_active   = enable && (state_q == S_DWELL);

  // State register.
  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; dropping enable always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_SETTLE;
        S_SETTLE:    if (settle_cnt_q == SETTLE_LAST) state_d = S_WAIT_LINK;
        S_WAIT_LINK: begin
          if (sel_locked)                      state_d = S_DWELL;
          else if (wait_cnt_q == TIMEOUT_LAST) state_d = S_REPORT;
        end
        S_DWELL:     if (target_hit || !sel_locked) state_d = S_REPORT;
        S_REPORT:    state_d = S_SETTLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output logic: mux, timers, frame assembler, counters, report.
  always_comb begin
    mux_data_d         = link_word[sel_ch_q];
    sel_ch_d           = sel_ch_q;
    settle_cnt_d       = '0;
    wait_cnt_d         = '0;
    primed_d           = 1'b0;
    run_len_d          = 3'd0;
    acc_d              = acc_q;
    good_cnt_d         = 16'd0;
    err_cnt_d          = 16'd0;
    frame_valid_d      = 1'b0;
    frame_data_d       = frame_data_q;
    result_valid_d     = 1'b0;
    result_ch_d        = result_ch_q;
    result_frames_d    = result_frames_q;
    result_errors_d    = result_errors_q;
    result_link_fail_d = result_link_fail_q;

    if (enable && state_q == S_SETTLE)    settle_cnt_d = settle_cnt_q + 1'b1;
    if (enable && state_q == S_WAIT_LINK) wait_cnt_d   = wait_cnt_q + 1'b1;

    // The assembler only primes on a non-header word, so a run already in
    // flight when DWELL starts is never mistaken for a complete frame.
    if (asm_active) begin
      primed_d   = primed_q;
      run_len_d  = run_len_q;
      good_cnt_d = good_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (!primed_q) begin
        if (!is_hdr) primed_d = 1'b1;
      end else if (is_hdr) begin
        if (run_len_q != 3'd7) run_len_d = run_len_q + 3'd1;
        acc_d = {acc_q[77:0], mux_data_q[25:0]};
      end else begin
        run_len_d = 3'd0;
        if (run_len_q == 3'd4) begin
          frame_valid_d = 1'b1;
          frame_data_d  = acc_q;
          good_cnt_d    = good_cnt_q + 16'd1;
        end else if (run_len_q != 3'd0 && err_cnt_q != 16'hFFFF) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
      end
    end

    // Latch the report on entry to REPORT, including this cycle's frame.
    if (state_d == S_REPORT && state_q != S_REPORT) begin
      result_valid_d     = 1'b1;
      result_ch_d        = sel_ch_q;
      result_frames_d    = good_cnt_d;
      result_errors_d    = err_cnt_d;
      result_link_fail_d = (state_q == S_WAIT_LINK) || !target_hit;
    end

    if (enable && state_q == S_REPORT)
      sel_ch_d = (sel_ch_q == CH_LAST) ? '0 : sel_ch_q + 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) begin
      sel_ch_q           <= '0;
      mux_data_q         <= '0;
      settle_cnt_q       <= '0;
      wait_cnt_q         <= '0;
      primed_q           <= 1'b0;
      run_len_q          <= 3'd0;
      acc_q              <= '0;
      good_cnt_q         <= 16'd0;
      err_cnt_q          <= 16'd0;
      frame_valid_q      <= 1'b0;
      frame_data_q       <= '0;
      result_valid_q     <= 1'b0;
      result_ch_q        <= '0;
      result_frames_q    <= 16'd0;
      result_errors_q    <= 16'd0;
      result_link_fail_q <= 1'b0;
    end else begin
      sel_ch_q           <= sel_ch_d;
      mux_data_q         <= mux_data_d;
      settle_cnt_q       <= settle_cnt_d;
      wait_cnt_q         <= wait_cnt_d;
      primed_q           <= primed_d;
      run_len_q          <= run_len_d;
      acc_q              <= acc_d;
      good_cnt_q         <= good_cnt_d;
      err_cnt_q          <= err_cnt_d;
      frame_valid_q      <= frame_valid_d;
      frame_data_q       <= frame_data_d;
      result_valid_q     <= result_valid_d;
      result_ch_q        <= result_ch_d;
      result_frames_q    <= result_frames_d;
      result_errors_q    <= result_errors_d;
      result_link_fail_q <= result_link_fail_d;
    end
  end

  assign sel_ch           = sel_ch_q;
  assign mux_data         = mux_data_q;
  assign frame_data       = frame_data_q;
  assign frame_valid      = frame_valid_q;
  assign result_valid     = result_valid_q;
  assign result_ch        = result_ch_q;
  assign result_frames    = result_frames_q;
  assign result_errors    = result_errors_q;
  assign result_link_fail = result_link_fail_q;
  assign state            = state_q;

endmodule
